product_acc: RTL and testbench

PRODUCT_ACC -- requirements
Module: product_acc

---
 rtl/product_acc.sv | 133 +++++++++++++
 tb/tb_product_acc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_acc.sv
// Accumulates NTERMS signed 32-bit products into a signed ACC_W sum behind a
// ready/valid handshake. Optional macro PRODUCT_ACC_SAT_EN saturates on overflow instead of wrapping.
module product_acc #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] nterms,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             ovf_r, ovf_s;
  logic             in_ready_r, out_valid_r, busy_r;
  logic [ACC_W-1:0] term_s, sum_s;
  logic             add_ovf_s;

  // Signed overflow: both operands share a sign that the result does not.
  function automatic logic add_overflows(input logic [ACC_W-1:0] a,
                                         input logic [ACC_W-1:0] b,
                                         input logic [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  function automatic logic [ACC_W-1:0] sat_limit(input logic negative);
    return negative ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  assign term_s    = {{(ACC_W-32){in_data[31]}}, in_data};
  assign sum_s     = acc_r + term_s;
  assign add_ovf_s = add_overflows(acc_r, term_s, sum_s);

  // Next-state and datapath decode; IN_READY is high only in ACCUM, so a transfer is just in_valid there.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    ovf_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_s = {ACC_W{1'b0}};
          ovf_s = 1'b0;
          if (nterms != CNT_ZERO) begin
            cnt_s   = nterms;
            state_s = ACCUM;
          end else begin
            cnt_s   = CNT_ZERO;
            state_s = HOLD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
`ifdef PRODUCT_ACC_SAT_EN
          acc_s = add_ovf_s ? sat_limit(acc_r[ACC_W-1]) : sum_s;
`else
          acc_s = sum_s;
`endif
          ovf_s = ovf_r | add_ovf_s;
          cnt_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_s = HOLD;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered status flags, decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= CNT_ZERO;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      ovf_r       <= ovf_s;
      in_ready_r  <= (state_s == ACCUM);
      out_valid_r <= (state_s == HOLD);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_data  = acc_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_product_acc.sv
// Bench for product_acc: a 40-bit and a 33-bit instance share all inputs and are
// checked against a table of known sums and an arithmetic reference model.
module tb_product_acc;

  localparam int CNT_W = 8;
`ifdef PRODUCT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] nterms = '0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = '0;
  logic             out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, busy_a, ovf_a;
  logic [39:0] out_a;
  logic        in_ready_b, out_valid_b, busy_b, ovf_b;
  logic [32:0] out_b;

  int checks = 0;
  int failures = 0;
  int terms [16];

  always #5 clk = ~clk;

  product_acc #(.ACC_W(40), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .start(start), .nterms(nterms),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_data(out_a), .out_ready(out_ready),
    .busy(busy_a), .ovf(ovf_a)
  );

  product_acc #(.ACC_W(33), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .start(start), .nterms(nterms),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_b), .out_ready(out_ready),
    .busy(busy_b), .ovf(ovf_b)
  );

  typedef struct {
    int     n;
    int     t0, t1, t2, t3;
    longint ea;
    bit     oa;
    longint eb_sat;
    bit     ob_sat;
    longint eb_wrap;
    bit     ob_wrap;
  } vec_t;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic longint sa(input logic [39:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sb(input logic [32:0] v);
    return longint'($signed(v));
  endfunction

  // Exact integer sum, folded back into the w-bit signed range after each term.
  function automatic void model(input int n, input int w, output longint sum, output bit o);
    longint mx, mn, m, e;
    m  = longint'(1) <<< w;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    sum = 0;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = sum + longint'(terms[i]);
      if (e > mx) begin
        o = 1'b1;
        sum = SAT ? mx : e - m;
      end else if (e < mn) begin
        o = 1'b1;
        sum = SAT ? mn : e + m;
      end else begin
        sum = e;
      end
    end
  endfunction

  task automatic check_idle_reset(input string name);
    chk({name, "_busy_a"}, busy_a, 0);
    chk({name, "_busy_b"}, busy_b, 0);
    chk({name, "_ready_a"}, in_ready_a, 0);
    chk({name, "_ovalid_a"}, out_valid_a, 0);
    chk({name, "_data_a"}, sa(out_a), 0);
    chk({name, "_data_b"}, sb(out_b), 0);
    chk({name, "_ovf_a"}, ovf_a, 0);
    chk({name, "_ovf_b"}, ovf_b, 0);
  endtask

  // Called at a falling edge while both instances are idle; returns at a falling edge, idle again.
  task automatic run(input string name, input int n, input int gap_max, input bit noise,
                     input int hold, input longint ea, input bit oa, input longint eb, input bit ob);
    int sent, cyc, gap;
    bit xfer;
    longint ha, hb;
    sent = 0;
    cyc = 0;
    start = 1'b1;
    nterms = CNT_W'(n);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_after_start"}, busy_a, 1);
    gap = $urandom_range(0, gap_max);
    while (sent < n && cyc < 500) begin
      chk({name, "_in_ready"}, in_ready_a, 1);
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = 1'b1;
        in_data = terms[sent];
      end
      start = noise && ($urandom_range(0, 2) == 0);
      nterms = CNT_W'($urandom_range(1, 255));
      xfer = in_valid && in_ready_a;
      @(posedge clk);
      if (xfer) begin
        sent++;
        gap = $urandom_range(0, gap_max);
      end
      @(negedge clk);
      in_valid = 1'b0;
      start = 1'b0;
      cyc++;
    end
    chk({name, "_transfers"}, sent, n);
    chk({name, "_ovalid_a"}, out_valid_a, 1);
    chk({name, "_ovalid_b"}, out_valid_b, 1);
    chk({name, "_in_ready_low"}, in_ready_a, 0);
    chk({name, "_sum_a"}, sa(out_a), ea);
    chk({name, "_ovf_a"}, ovf_a, oa);
    chk({name, "_sum_b"}, sb(out_b), eb);
    chk({name, "_ovf_b"}, ovf_b, ob);
    ha = sa(out_a);
    hb = sb(out_b);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      start = (i % 3 == 0);
      nterms = CNT_W'(3);
      @(posedge clk);
      @(negedge clk);
      chk({name, "_hold_data_a"}, sa(out_a), ha);
      chk({name, "_hold_data_b"}, sb(out_b), hb);
      chk({name, "_hold_valid"}, out_valid_a, 1);
      chk({name, "_hold_ovf_a"}, ovf_a, oa);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    nterms = CNT_W'(3);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    chk({name, "_done_busy"}, busy_a, 0);
    chk({name, "_done_ovalid"}, out_valid_a, 0);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_no_new_run"}, busy_b, 0);
  endtask

  initial begin
    vec_t vecs [7];
    longint ma, mb;
    bit moa, mob;
    int n;

    vecs[0] = '{3, 100, -40, 7, 0, 67, 1'b0, 67, 1'b0, 67, 1'b0};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    vecs[2] = '{3, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0,
                64'sd6442450941, 1'b0, 64'sd4294967295, 1'b1, -64'sd2147483651, 1'b1};
    vecs[3] = '{2, 32'h80000000, 32'h80000000, 0, 0,
                -64'sd4294967296, 1'b0, -64'sd4294967296, 1'b0, -64'sd4294967296, 1'b0};
    vecs[4] = '{4, 10, -20, 30, -40, -20, 1'b0, -20, 1'b0, -20, 1'b0};
    vecs[5] = '{1, -5, 0, 0, 0, -5, 1'b0, -5, 1'b0, -5, 1'b0};
    vecs[6] = '{4, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                -64'sd8589934592, 1'b0, -64'sd4294967296, 1'b1, 0, 1'b1};

    #12;
    check_idle_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table vectors; entry 4 adds input gaps, START noise and a long HOLD.
    for (int i = 0; i < 7; i++) begin
      terms[0] = vecs[i].t0;
      terms[1] = vecs[i].t1;
      terms[2] = vecs[i].t2;
      terms[3] = vecs[i].t3;
      run($sformatf("vec%0d", i), vecs[i].n, (i == 4) ? 3 : 0, (i == 4), (i == 4) ? 10 : 2,
          vecs[i].ea, vecs[i].oa,
          SAT ? vecs[i].eb_sat : vecs[i].eb_wrap, SAT ? vecs[i].ob_sat : vecs[i].ob_wrap);
    end

    // Reset in the middle of a five-term run.
    terms[0] = 1000;
    start = 1'b1;
    nterms = CNT_W'(5);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 32'd1000;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("abort_partial", sa(out_a), 2000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_reset("abort_async");
    @(negedge clk);
    rst = 1'b0;
    terms[0] = 5;
    run("after_abort", 1, 0, 1'b0, 1, 5, 1'b0, 5, 1'b0);

    // Random runs against the reference model, with occasional extreme products.
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: terms[i] = 32'h7FFFFFFF;
          1: terms[i] = 32'h80000000;
          2: terms[i] = $urandom_range(0, 2000) - 1000;
          default: terms[i] = $urandom;
        endcase
      end
      model(n, 40, ma, moa);
      model(n, 33, mb, mob);
      run($sformatf("rand%0d", r), n, 2, r[0], r % 4, ma, moa, mb, mob);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
